// File: rtl/alu_pkg.sv
// Purpose: shared op-class encodings and flag bit positions for the pipelined ALU.
// Latency: n/a (definitions only).
// Backpressure: n/a.
// Contents: OP_* values of sel[3:2]; FLAG_* indices into the packed flag word.
package alu_pkg;

  // Op class, taken from sel[3:2]
  localparam logic [1:0] OP_ARITH = 2'b00;
  localparam logic [1:0] OP_LOGIC = 2'b01;
  localparam logic [1:0] OP_SHR   = 2'b10;
  localparam logic [1:0] OP_SHL   = 2'b11;

  // Bit positions inside the registered flag word
  localparam int FLAG_COUT = 0;
  localparam int FLAG_ZERO = 1;
  localparam int FLAG_NEG  = 2;
  localparam int FLAG_OVF  = 3;
  localparam int FLAG_W    = 4;

  typedef logic [FLAG_W-1:0] flags_t;

endpackage

// File: rtl/alu_core.sv
// Purpose: combinational ALU datapath, (a,b,cin,sel) -> (f,cout,ovf).
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the enclosing pipeline decides when results are captured.
// Ports: a,b operands; cin carry in (arith only); sel op select;
//        f result; cout carry / last bit shifted out; ovf signed overflow (arith only).
// Build option: ALU_BARREL_SHIFT_EN selects shift-by-b[SHW-1:0] instead of shift-by-1.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [3:0]       sel,
  output logic [WIDTH-1:0] f,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] x;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] shr_f;
  logic             shr_c;
  logic [WIDTH-1:0] shl_f;
  logic             shl_c;

  always_comb begin
    x = '0;
    case (sel[1:0])
      2'b00:   x = '0;
      2'b01:   x = b;
      2'b10:   x = ~b;
      default: x = '1;
    endcase
  end

  // One extra bit so the carry out of bit WIDTH-1 is visible
  assign sum = {1'b0, a} + {1'b0, x} + {{WIDTH{1'b0}}, cin};

`ifdef ALU_BARREL_SHIFT_EN
  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0]   sh;
  logic [WIDTH:0]   shr_ext;
  logic [WIDTH:0]   shl_ext;
  logic [WIDTH-1:0] sra;

  assign sh = b[SHW-1:0];
  // A guard bit below / above the operand catches the last bit shifted out;
  // for sh==0 the guard is a constant 0, giving cout=0 without a special case.
  assign shr_ext = {a, 1'b0} >> sh;
  assign shl_ext = {1'b0, a} << sh;
  assign sra     = $signed(a) >>> sh;

  assign shr_f = sel[0] ? sra : shr_ext[WIDTH:1];
  assign shr_c = shr_ext[0];
  assign shl_f = shl_ext[WIDTH-1:0];
  assign shl_c = shl_ext[WIDTH];
`else
  assign shr_f = {sel[0] & a[WIDTH-1], a[WIDTH-1:1]};
  assign shr_c = a[0];
  assign shl_f = {a[WIDTH-2:0], 1'b0};
  assign shl_c = a[WIDTH-1];
`endif

  always_comb begin
    f    = '0;
    cout = 1'b0;
    ovf  = 1'b0;
    case (sel[3:2])
      OP_ARITH: begin
        f    = sum[WIDTH-1:0];
        cout = sum[WIDTH];
        ovf  = (a[WIDTH-1] == x[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_LOGIC: begin
        case (sel[1:0])
          2'b00:   f = a & b;
          2'b01:   f = a | b;
          2'b10:   f = a ^ b;
          default: f = ~a;
        endcase
      end
      OP_SHR: begin
        f    = shr_f;
        cout = shr_c;
      end
      default: begin
        f    = shl_f;
        cout = shl_c;
      end
    endcase
  end

endmodule

// File: rtl/alu_pipelined.sv
// Purpose: two-stage valid/ready ALU pipeline (S1 operand regs, S2 result+flag regs).
// Latency: 2 cycles accept->out_valid; 1 op/cycle sustained.
// Backpressure: out_ready=0 stalls S2, then S1; in_ready drops only when both stages hold data.
// Ports: clk, rst_n (async active-low); in_valid/in_ready + a,b,cin,sel;
//        out_valid/out_ready + f,cout,zero,neg,ovf.
// Build option: ALU_BARREL_SHIFT_EN (passed through to alu_core).
module alu_pipelined
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [3:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             cout,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_cin;
  logic [3:0]       s1_sel;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_f;
  flags_t           s2_flags;

  logic             s1_load;
  logic             s2_load;

  logic [WIDTH-1:0] core_f;
  logic             core_cout;
  logic             core_ovf;

  // Ready chains backwards from the consumer; in_valid never feeds in_ready.
  assign s2_load  = !s2_valid | out_ready;
  assign s1_load  = !s1_valid | s2_load;
  assign in_ready = s1_load;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a    (s1_a),
    .b    (s1_b),
    .cin  (s1_cin),
    .sel  (s1_sel),
    .f    (core_f),
    .cout (core_cout),
    .ovf  (core_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_cin   <= 1'b0;
      s1_sel   <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a   <= a;
        s1_b   <= b;
        s1_cin <= cin;
        s1_sel <= sel;
      end
    end
  end

  // Result regs only change when a real op moves in, so f holds across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_f     <= '0;
      s2_flags <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_f                <= core_f;
        s2_flags[FLAG_COUT] <= core_cout;
        s2_flags[FLAG_ZERO] <= (core_f == '0);
        s2_flags[FLAG_NEG]  <= core_f[WIDTH-1];
        s2_flags[FLAG_OVF]  <= core_ovf;
      end
    end
  end

  assign out_valid = s2_valid;
  assign f         = s2_f;
  assign cout      = s2_flags[FLAG_COUT];
  assign zero      = s2_flags[FLAG_ZERO];
  assign neg       = s2_flags[FLAG_NEG];
  assign ovf       = s2_flags[FLAG_OVF];

endmodule

// File: tb/tb_alu_pipelined.sv
// Purpose: directed self-checking bench for alu_pipelined (WIDTH=32).
// Latency: checks the 2-cycle accept->out_valid timing on every op.
// Backpressure: exercises a full stall, in-order drain and reset while full.
module tb_alu_pipelined;

  localparam int W = 32;
  localparam logic [W-1:0] A0 = 32'hA5A5F0F0;
  localparam logic [W-1:0] B0 = 32'h0F0F5A5A;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [3:0]   sel;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] f;
  logic         cout;
  logic         zero;
  logic         neg;
  logic         ovf;

  int n_cmp = 0;
  int n_err = 0;

  alu_pipelined #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .f         (f),
    .cout      (cout),
    .zero      (zero),
    .neg       (neg),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Flags packed as {cout, zero, neg, ovf}
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                       input logic [3:0] ts);
    in_valid = 1'b1;
    a        = ta;
    b        = tb_;
    cin      = tc;
    sel      = ts;
  endtask

  // Single op with out_ready=1; entered and left on a negedge.
  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic tc, input logic [3:0] ts,
                        input logic [W-1:0] ef, input logic [3:0] efl);
    drive(ta, tb_, tc, ts);
    #1;
    chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    a   = 'x;
    b   = 'x;
    cin = 1'bx;
    #1;
    chk({tag, ".early"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    #1;
    chk({tag, ".out_valid"}, 64'(out_valid), 64'd1);
    chk({tag, ".f"}, 64'(f), 64'(ef));
    chk({tag, ".flags"}, 64'({cout, zero, neg, ovf}), 64'(efl));
    @(negedge clk);
  endtask

  logic [W-1:0] exp_q[3];
  int           got;
  bit           clr;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a   = '0;
    b   = '0;
    cin = 1'b0;
    sel = '0;
    #12;
    chk("reset.out_valid", 64'(out_valid), 64'd0);
    chk("reset.in_ready", 64'(in_ready), 64'd1);
    chk("reset.f", 64'(f), 64'd0);
    chk("reset.flags", 64'({cout, zero, neg, ovf}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Arithmetic
    run_op("add",      A0, B0, 1'b0, 4'b0001, 32'hB4B54B4A, 4'b0010);
    run_op("sub",      A0, B0, 1'b1, 4'b0010, 32'h96969696, 4'b1010);
    run_op("add_ovf",  32'h7FFFFFFF, 32'h1, 1'b0, 4'b0001, 32'h80000000, 4'b0011);
    run_op("dec",      32'h0, B0, 1'b0, 4'b0011, 32'hFFFFFFFF, 4'b0010);
    run_op("sub_zero", A0, A0, 1'b1, 4'b0010, 32'h0, 4'b1100);
    run_op("pass_cin", A0, B0, 1'b1, 4'b0000, 32'hA5A5F0F1, 4'b0010);
    // Logic (cin ignored)
    run_op("and",      A0, B0, 1'b1, 4'b0100, 32'h05055050, 4'b0000);
    run_op("or",       A0, B0, 1'b0, 4'b0101, 32'hAFAFFAFA, 4'b0010);
    run_op("xor",      A0, B0, 1'b0, 4'b0110, 32'hAAAAAAAA, 4'b0010);
    run_op("not",      A0, B0, 1'b0, 4'b0111, 32'h5A5A0F0F, 4'b0000);
`ifdef ALU_BARREL_SHIFT_EN
    run_op("shr26",    A0, 32'h1A, 1'b0, 4'b1000, 32'h00000029, 4'b0000);
    run_op("sra26",    A0, 32'h1A, 1'b0, 4'b1001, 32'hFFFFFFE9, 4'b0010);
    run_op("shl0",     A0, 32'h0,  1'b0, 4'b1100, 32'hA5A5F0F0, 4'b0010);
    run_op("shl1",     A0, 32'h1,  1'b0, 4'b1111, 32'h4B4BE1E0, 4'b1000);
    run_op("shr0",     A0, 32'h0,  1'b0, 4'b1001, 32'hA5A5F0F0, 4'b0010);
`else
    run_op("shr1",     A0, B0, 1'b0, 4'b1000, 32'h52D2F878, 4'b0000);
    run_op("sra1",     A0, B0, 1'b0, 4'b1001, 32'hD2D2F878, 4'b0010);
    run_op("sra1_s1",  A0, B0, 1'b0, 4'b1011, 32'hD2D2F878, 4'b0010);
    run_op("shl1",     A0, B0, 1'b0, 4'b1100, 32'h4B4BE1E0, 4'b1000);
    run_op("shl1_s11", A0, B0, 1'b0, 4'b1111, 32'h4B4BE1E0, 4'b1000);
`endif

    // Backpressure: fill both stages, hold the third op
    exp_q[0] = 32'hB4B54B4A;
    exp_q[1] = 32'h05055050;
    exp_q[2] = 32'hAAAAAAAA;
    out_ready = 1'b0;
    drive(A0, B0, 1'b0, 4'b0001);
    #1;
    chk("bp.rdy1", 64'(in_ready), 64'd1);
    @(negedge clk);
    drive(A0, B0, 1'b0, 4'b0100);
    #1;
    chk("bp.rdy2", 64'(in_ready), 64'd1);
    @(negedge clk);
    drive(A0, B0, 1'b0, 4'b0110);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp.full_rdy", 64'(in_ready), 64'd0);
      chk("bp.full_vld", 64'(out_valid), 64'd1);
      chk("bp.stable_f", 64'(f), 64'(exp_q[0]));
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.rdy_release", 64'(in_ready), 64'd1);
    got = 0;
    clr = 1'b0;
    for (int cyc = 0; cyc < 10 && got < 3; cyc++) begin
      if (out_valid) begin
        chk($sformatf("bp.order%0d", got), 64'(f), 64'(exp_q[got]));
        got++;
      end
      clr = in_valid && in_ready;
      @(negedge clk);
      if (clr) in_valid = 1'b0;
      #1;
    end
    chk("bp.count", 64'(got), 64'd3);
    chk("bp.no_dup", 64'(out_valid), 64'd0);

    // Reset with two ops in flight
    @(negedge clk);
    out_ready = 1'b0;
    drive(A0, B0, 1'b1, 4'b0010);
    @(negedge clk);
    drive(A0, B0, 1'b0, 4'b0111);
    @(negedge clk);
    #1;
    chk("rst.pre_full", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.f", 64'(f), 64'd0);
    chk("rst.flags", 64'({cout, zero, neg, ovf}), 64'd0);
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    // in_valid is still high here; nothing may enter while held in reset
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("rst.empty", 64'(out_valid), 64'd0);
    end
    @(negedge clk);
    run_op("post_rst", A0, B0, 1'b0, 4'b0101, 32'hAFAFFAFA, 4'b0010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed hang expected completion");
    $fatal(1, "timeout");
  end

endmodule
